// File: rtl/controller_sequencer.sv
// controller_sequencer: SAP-1 T1..T6 ring counter that turns one-hot decode lines into the datapath control word.
// Controls are combinational from the ring state. Define SINGLE_STEP_EN to add step_mode/step gating of the ring and strobes.
module controller_sequencer #(
  parameter int ALU_OP_W    = 3,
  parameter int EARLY_FETCH = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                lda,
  input  logic                add,
  input  logic                sub,
  input  logic                out,
  input  logic                low_halt,
  input  logic                xor_ratna,
  input  logic                and_ratna,
  input  logic                or_ratna,
  input  logic                cmp_ratna,
  input  logic                lda_imm,
  input  logic                sta_imm,
  input  logic                add_new,
  output logic                pc_out,
  output logic                pc_inc,
  output logic                mar_ld,
  output logic                ram_out,
  output logic                ram_we,
  output logic                ir_ld,
  output logic                ir_out,
  output logic                a_ld,
  output logic                a_out,
  output logic                b_ld,
  output logic                alu_out,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                flags_ld,
  output logic                out_ld,
  output logic                halted,
  output logic [5:0]          t_state
`ifdef SINGLE_STEP_EN
  ,
  input  logic                step_mode,
  input  logic                step
`endif
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } t_state_e;

  typedef struct packed {
    logic                pc_out, pc_inc, mar_ld, ram_out, ram_we, ir_ld, ir_out;
    logic                a_ld, a_out, b_ld, alu_out, flags_ld, out_ld;
    logic [ALU_OP_W-1:0] alu_op;
  } ctrl_t;

  t_state_e state_q, state_d;
  logic     halted_q, halted_d;
  ctrl_t    ctrl, ctrl_g;
  logic     advance;
  logic     single, is_lda, is_alu, is_cmp, is_ldi, is_sta, is_out, is_nop;
  logic [10:0] dec_v;
  logic [ALU_OP_W-1:0] alu_code;

`ifdef SINGLE_STEP_EN
  assign advance = ~step_mode | step;
`else
  assign advance = 1'b1;
`endif

  // Anything other than exactly one decode line is treated as a NOP.
  assign dec_v  = {add_new, sta_imm, lda_imm, cmp_ratna, or_ratna, and_ratna,
                   xor_ratna, out, sub, add, lda};
  assign single = $onehot(dec_v);
  assign is_lda = single & lda;
  assign is_alu = single & (add | sub | xor_ratna | and_ratna | or_ratna | add_new);
  assign is_cmp = single & cmp_ratna;
  assign is_ldi = single & lda_imm;
  assign is_sta = single & sta_imm;
  assign is_out = single & out;
  assign is_nop = ~single;

  always_comb begin
    alu_code = ALU_OP_W'(0);
    if (add_new)        alu_code = ALU_OP_W'(6);
    else if (or_ratna)  alu_code = ALU_OP_W'(4);
    else if (and_ratna) alu_code = ALU_OP_W'(3);
    else if (xor_ratna) alu_code = ALU_OP_W'(2);
    else if (sub)       alu_code = ALU_OP_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= T1;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    ctrl     = '0;
    if (!halted_q) begin
      case (state_q)
        T1: begin ctrl.pc_out = 1'b1; ctrl.mar_ld = 1'b1; state_d = T2; end
        T2: begin ctrl.pc_inc = 1'b1; state_d = T3; end
        T3: begin ctrl.ram_out = 1'b1; ctrl.ir_ld = 1'b1; state_d = T4; end
        T4: begin
          if (!low_halt) begin
            halted_d = 1'b1;
          end else begin
            if (is_lda | is_alu | is_cmp | is_sta) begin
              ctrl.ir_out = 1'b1; ctrl.mar_ld = 1'b1;
            end
            if (is_ldi) begin ctrl.ir_out = 1'b1; ctrl.a_ld = 1'b1; end
            if (is_out) begin ctrl.a_out = 1'b1; ctrl.out_ld = 1'b1; end
            state_d = ((EARLY_FETCH != 0) && (is_ldi | is_out | is_nop)) ? T1 : T5;
          end
        end
        T5: begin
          if (is_lda) begin ctrl.ram_out = 1'b1; ctrl.a_ld = 1'b1; end
          if (is_alu | is_cmp) begin ctrl.ram_out = 1'b1; ctrl.b_ld = 1'b1; end
          if (is_sta) begin ctrl.a_out = 1'b1; ctrl.ram_we = 1'b1; end
          state_d = ((EARLY_FETCH != 0) && (is_lda | is_sta)) ? T1 : T6;
        end
        T6: begin
          if (is_alu) begin
            ctrl.alu_out = 1'b1; ctrl.a_ld = 1'b1; ctrl.flags_ld = 1'b1;
            ctrl.alu_op  = alu_code;
          end
          if (is_cmp) begin ctrl.flags_ld = 1'b1; ctrl.alu_op = ALU_OP_W'(5); end
          state_d = T1;
        end
        default: state_d = T1;
      endcase
    end
    if (!advance) begin
      state_d  = state_q;
      halted_d = halted_q;
    end
  end

  // Reset and a held step both suppress every strobe for the cycle.
  assign ctrl_g = (rst || !advance) ? '0 : ctrl;

  assign pc_out   = ctrl_g.pc_out;
  assign pc_inc   = ctrl_g.pc_inc;
  assign mar_ld   = ctrl_g.mar_ld;
  assign ram_out  = ctrl_g.ram_out;
  assign ram_we   = ctrl_g.ram_we;
  assign ir_ld    = ctrl_g.ir_ld;
  assign ir_out   = ctrl_g.ir_out;
  assign a_ld     = ctrl_g.a_ld;
  assign a_out    = ctrl_g.a_out;
  assign b_ld     = ctrl_g.b_ld;
  assign alu_out  = ctrl_g.alu_out;
  assign alu_op   = ctrl_g.alu_op;
  assign flags_ld = ctrl_g.flags_ld;
  assign out_ld   = ctrl_g.out_ld;
  assign halted   = halted_q;
  assign t_state  = state_q;

endmodule
